mau_res_fifo: RTL and testbench

- Result buffer between alu_stage and the SPI tx stage.
- Decouples ALU issue rate from slow SPI readout, so several instructions can complete before the host reads.
- Stores {carry, 18-bit result} entries in a DEPTH-deep first-word-fall-through FIFO.
- Uses valid/ready handshakes on both sides and exposes occupancy for status and debug.

---
 rtl/mau_pkg.sv | 29 ++
 rtl/mau_res_fifo.sv | 159 +++++++++++++++
 tb/tb_mau_res_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared types and constants for the MAU datapath (alu_stage, mau_res_fifo, tx).
//
// Contents:
//   RES_W        width of the ALU result bus
//   DEPTH_DEF    default result-buffer depth
//   res_entry_t  one buffered result: {carry, data}
//   make_entry   packs a carry/data pair into a res_entry_t
// -----------------------------------------------------------------------------
package mau_pkg;

    localparam int RES_W     = 18;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic             carry;
        logic [RES_W-1:0] data;
    } res_entry_t;

    // Builds a buffer entry from the ALU result and carry.
    function automatic res_entry_t make_entry(input logic c, input logic [RES_W-1:0] d);
        res_entry_t e;
        e.carry = c;
        e.data  = d;
        return e;
    endfunction

endpackage

// File: rtl/mau_res_fifo.sv
// -----------------------------------------------------------------------------
// mau_res_fifo
// Result buffer between alu_stage and the SPI tx stage. It holds up to DEPTH
// {carry, result} entries so the ALU can keep completing instructions while
// the host is still reading earlier results over SPI. The FIFO is
// first-word-fall-through: the head entry is visible on out_data/out_carry
// as soon as out_valid is high.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   flush      in   synchronous clear of all stored entries
//   in_valid   in   ALU result valid
//   in_ready   out  FIFO can accept an entry this cycle
//   in_data    in   ALU result
//   in_carry   in   ALU carry
//   out_valid  out  head entry available
//   out_ready  in   consumer takes the head entry
//   out_data   out  head result (0 when empty)
//   out_carry  out  head carry (0 when empty)
//   count      out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mau_res_fifo #(
    parameter int RES_W = mau_pkg::RES_W,
    parameter int DEPTH = mau_pkg::DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_data,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic             out_carry,
    output logic [CNT_W-1:0] count
);

    import mau_pkg::*;

    // DEPTH must be a power of two >= 2, so the pointers are exactly
    // log2(DEPTH) bits wide and a full FIFO is distinguished from an empty
    // one only by the occupancy counter.
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Entry storage; intentionally not reset, only the pointers qualify it.
    res_entry_t mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    res_entry_t       head_s;

    // Status decode from registered occupancy only.
    always_comb begin
        full_s  = (count_r == CNT_FULL);
        empty_s = (count_r == {CNT_W{1'b0}});
    end

    // Upstream acceptance: depends only on rst/flush and registered state,
    // so a same-cycle pop at full does not open in_ready.
    always_comb begin
        if (rst || flush) begin
            in_ready = 1'b0;
        end else begin
            in_ready = !full_s;
        end
    end

    // Handshake qualification for both sides.
    always_comb begin
        push_s = in_valid && in_ready;
        pop_s  = out_valid && out_ready;
    end

    // Next pointer values with explicit wrap at DEPTH-1.
    always_comb begin
        if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end
        if (rd_ptr_r == PTR_LAST) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end
    end

    // Pointer and occupancy state; reset and flush both discard all entries.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_nxt_s;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_nxt_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry write; push_s is already blocked during rst/flush via in_ready.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= make_entry(in_carry, in_data);
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Head read straight from storage: no bypass from the input side.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
    end

    // Output side: head is shown only when valid, otherwise zeros.
    always_comb begin
        out_valid = !empty_s;
        if (!empty_s) begin
            out_data  = head_s.data;
            out_carry = head_s.carry;
        end else begin
            out_data  = {RES_W{1'b0}};
            out_carry = 1'b0;
        end
    end

    // Occupancy is exported directly from the registered counter.
    always_comb begin
        count = count_r;
    end

endmodule

// File: tb/tb_mau_res_fifo.sv
// -----------------------------------------------------------------------------
// tb_mau_res_fifo
// Self-checking bench for mau_res_fifo (DEPTH=4). A queue model tracks the
// expected contents; every cycle the DUT's in_ready/out_valid/out_data/
// out_carry/count are compared with the model before the clock edge. A table
// of stimulus records additionally carries a hand-derived occupancy expected
// after each edge.
// -----------------------------------------------------------------------------
module tb_mau_res_fifo;

    localparam int RES_W = 18;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] in_data;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic             out_carry;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    mau_res_fifo #(
        .RES_W(RES_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_carry (in_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .count    (count)
    );

    typedef struct {
        logic             rs;
        logic             fl;
        logic             iv;
        logic [RES_W-1:0] d;
        logic             c;
        logic             ordy;
        int               exp_cnt;
    } vec_t;

    vec_t             tbl[$];
    logic [RES_W:0]   sb[$];   // {carry, data}, head at index 0
    int               n_pass  = 0;
    int               n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rs, input logic fl, input logic iv,
                                input logic [RES_W-1:0] d, input logic c,
                                input logic ordy, input int exp_cnt);
        vec_t v;
        v.rs = rs; v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.exp_cnt = exp_cnt;
        tbl.push_back(v);
    endfunction

    // Drive one cycle (inputs applied 1 ns after the edge), check outputs
    // against the model, update the model, advance past the next edge.
    task automatic cycle(input logic rs, input logic fl, input logic iv,
                         input logic [RES_W-1:0] d, input logic c, input logic ordy);
        logic           exp_rdy;
        logic [RES_W:0] head;
        rst = rs; flush = fl; in_valid = iv; in_data = d; in_carry = c; out_ready = ordy;
        #1;
        exp_rdy = !rs && !fl && (sb.size() != DEPTH);
        head    = (sb.size() != 0) ? sb[0] : {(RES_W+1){1'b0}};
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("out_data",  32'(out_data),  32'(head[RES_W-1:0]));
        chk("out_carry", 32'(out_carry), 32'(head[RES_W]));
        chk("count",     32'(count),     32'(sb.size()));
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (ordy && sb.size() != 0) void'(sb.pop_front());
            if (iv && exp_rdy) sb.push_back({c, d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_carry = 1'b0; out_ready = 1'b0;

        // Initial reset: DUT state is unknown until the first edge.
        @(posedge clk);
        #1;
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);

        // Reset then idle.
        cycle(1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_out_data", 32'(out_data), 32'd0);

        // Two pushes with out_ready low; head must stay 0x3FFFF/1.
        cycle(1'b0, 1'b0, 1'b1, 18'h3FFFF, 1'b1, 1'b0);
        chk("ffwt_latency_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 18'h00001, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
            chk("hold_count", 32'(count), 32'd2);
            chk("hold_data",  32'(out_data), 32'h3FFFF);
            chk("hold_carry", 32'(out_carry), 32'd1);
        end

        // Drain the two, then pop attempts on empty.
        add(0, 0, 0, 18'h0, 0, 1, 1);
        add(0, 0, 0, 18'h0, 0, 1, 0);
        add(0, 0, 0, 18'h0, 0, 1, 0);
        // Fill with 1..4, fifth refused.
        add(0, 0, 1, 18'd1, 0, 0, 1);
        add(0, 0, 1, 18'd2, 1, 0, 2);
        add(0, 0, 1, 18'd3, 0, 0, 3);
        add(0, 0, 1, 18'd4, 1, 0, 4);
        add(0, 0, 1, 18'd5, 0, 0, 4);
        // Full with push and pop together: pop only.
        add(0, 0, 1, 18'd6, 1, 1, 3);
        // Drain the rest, then one pop on empty.
        add(0, 0, 0, 18'h0, 0, 1, 2);
        add(0, 0, 0, 18'h0, 0, 1, 1);
        add(0, 0, 0, 18'h0, 0, 1, 0);
        add(0, 0, 0, 18'h0, 0, 1, 0);
        // Steady stream at count=2 across pointer wrap.
        add(0, 0, 1, 18'h10, 0, 0, 1);
        add(0, 0, 1, 18'h11, 1, 0, 2);
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 1, 18'(32'h12 + k), k[0], 1, 2);
        end
        add(0, 0, 0, 18'h0, 0, 1, 1);
        add(0, 0, 0, 18'h0, 0, 1, 0);
        // Count=3, flush with in_valid high.
        add(0, 0, 1, 18'h20, 0, 0, 1);
        add(0, 0, 1, 18'h21, 1, 0, 2);
        add(0, 0, 1, 18'h22, 0, 0, 3);
        add(0, 1, 1, 18'h23, 1, 1, 0);
        add(0, 0, 0, 18'h0, 0, 0, 0);
        // Reset during operation.
        add(0, 0, 1, 18'h30, 1, 0, 1);
        add(0, 0, 1, 18'h31, 0, 0, 2);
        add(1, 0, 1, 18'h32, 1, 0, 0);
        add(0, 0, 1, 18'h33, 1, 0, 1);
        add(0, 0, 0, 18'h0, 0, 1, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].rs, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
        end

        // Final state: empty, zeroed outputs.
        cycle(1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_out_data", 32'(out_data), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
